// File: rtl/bf16_mult_arbiter.sv
// Round-robin arbiter sharing one pipelined bf16 multiplier among NUM_REQ requesters,
// with tagged in-flight ops and one-hot result return.
package bf16_mult_arbiter_pkg;
    typedef enum logic [3:0] {
        FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX,
        CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
    } fp_op_e;

    typedef enum logic [2:0] {
        FP32, FP64, FP16, FP8, FP16ALT
    } fp_fmt_e;
endpackage

module bf16_mult_arbiter
    import bf16_mult_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int MULT_LAT = 1,
    parameter int IDX_W    = $clog2(NUM_REQ)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  fp_op_e                            req_opcode [NUM_REQ],
    input  fp_fmt_e                           req_fmt    [NUM_REQ],
    input  logic [NUM_REQ*32-1:0]             req_x,
    input  logic [NUM_REQ*32-1:0]             req_y,
    input  logic [NUM_REQ-1:0]                req_en,
    input  logic                              hold,
    output fp_op_e                            mul_opcode,
    output fp_fmt_e                           mul_fmt,
    output logic [31:0]                       mul_x,
    output logic [31:0]                       mul_y,
    input  logic [31:0]                       mul_r,
    output logic [NUM_REQ-1:0]                rsp_valid,
    output logic [31:0]                       rsp_data,
    output logic [$clog2(MULT_LAT+3)-1:0]     inflight,
    output logic                              busy
);
    localparam int DEPTH = MULT_LAT + 1;
    localparam int CNT_W = $clog2(MULT_LAT + 3);

    logic [IDX_W-1:0]   ptr;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               found;
    logic               accept;
    logic [NUM_REQ-1:0] rsp_q;
    logic               tag_valid [DEPTH];
    logic [IDX_W-1:0]   tag_idx   [DEPTH];

    assign eligible = req_valid & req_en & {NUM_REQ{~hold}};

    // Scan from the pointer upward, wrapping modulo NUM_REQ; first eligible wins.
    always_comb begin
        logic [IDX_W-1:0] idx;
        idx       = '0;
        found     = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (!found && eligible[idx]) begin
                found     = 1'b1;
                grant_idx = idx;
            end
        end
        grant = (found && !rst) ? (NUM_REQ'(1) << grant_idx) : '0;
    end

    assign req_ready = grant;
    assign accept    = |(grant & req_valid);
    assign rsp_valid = rsp_q & {NUM_REQ{~rst}};
    assign busy      = (inflight != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr        <= '0;
            mul_x      <= '0;
            mul_y      <= '0;
            mul_opcode <= FMADD;
            mul_fmt    <= FP32;
            rsp_q      <= '0;
            rsp_data   <= '0;
            inflight   <= '0;
            for (int s = 0; s < DEPTH; s++) begin
                tag_valid[s] <= 1'b0;
                tag_idx[s]   <= '0;
            end
        end else begin
            if (accept) begin
                ptr        <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
                mul_x      <= req_x[int'(grant_idx)*32 +: 32];
                mul_y      <= req_y[int'(grant_idx)*32 +: 32];
                mul_opcode <= req_opcode[grant_idx];
                mul_fmt    <= req_fmt[grant_idx];
            end

            // Tags march alongside the multiplier pipeline; the last stage lines up with valid mul_r.
            tag_valid[0] <= accept;
            tag_idx[0]   <= grant_idx;
            for (int s = 1; s < DEPTH; s++) begin
                tag_valid[s] <= tag_valid[s-1];
                tag_idx[s]   <= tag_idx[s-1];
            end

            if (tag_valid[DEPTH-1]) begin
                rsp_data <= mul_r;
                rsp_q    <= NUM_REQ'(1) << tag_idx[DEPTH-1];
            end else begin
                rsp_q    <= '0;
            end

            case ({accept, |rsp_q})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end
endmodule

// File: tb/tb_bf16_mult_arbiter.sv
// Directed bench for bf16_mult_arbiter with a one-stage multiplier stub.
module tb_bf16_mult_arbiter;
    import bf16_mult_arbiter_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    fp_op_e       req_opcode [4];
    fp_fmt_e      req_fmt    [4];
    logic [127:0] req_x;
    logic [127:0] req_y;
    logic [3:0]   req_en;
    logic         hold;
    fp_op_e       mul_opcode;
    fp_fmt_e      mul_fmt;
    logic [31:0]  mul_x;
    logic [31:0]  mul_y;
    logic [31:0]  mul_r = 32'h0;
    logic [3:0]   rsp_valid;
    logic [31:0]  rsp_data;
    logic [1:0]   inflight;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    bf16_mult_arbiter #(.NUM_REQ(4), .MULT_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_fmt(req_fmt),
        .req_x(req_x), .req_y(req_y), .req_en(req_en), .hold(hold),
        .mul_opcode(mul_opcode), .mul_fmt(mul_fmt),
        .mul_x(mul_x), .mul_y(mul_y), .mul_r(mul_r),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .inflight(inflight), .busy(busy)
    );

    always #5 clk = ~clk;

    // Truncating multiply for normal operands, enough for the exact products used here.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [22:0] frac;
        int          e;
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            frac = p[46:24];
            e    = e + 1;
        end else begin
            frac = p[45:23];
        end
        return {a[31] ^ b[31], e[7:0], frac};
    endfunction

    always @(posedge clk) mul_r <= fmul(mul_x, mul_y);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [31:0] x, input logic [31:0] y);
        req_x[32*i +: 32] = x;
        req_y[32*i +: 32] = y;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    logic [31:0] fair_r [4] = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000};
    logic [31:0] bb_x   [5] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
    logic [31:0] bb_r   [5] = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000, 32'h41200000};

    initial begin
        #100000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int acc;
        int rs;
        rst       = 1'b1;
        req_valid = 4'hF;
        req_en    = 4'hF;
        hold      = 1'b0;
        req_x     = '0;
        req_y     = '0;
        for (int i = 0; i < 4; i++) begin
            req_opcode[i] = MUL;
            req_fmt[i]    = FP16ALT;
        end

        // Reset: grants suppressed while rst is high, then all outputs at reset values.
        tick();
        check_output("ready_during_rst", 32'(req_ready), 32'h0);
        tick();
        rst       = 1'b0;
        req_valid = 4'h0;
        #1;
        check_output("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check_output("rst_rsp_data", rsp_data, 32'h0);
        check_output("rst_mul_x", mul_x, 32'h0);
        check_output("rst_mul_y", mul_y, 32'h0);
        check_output("rst_mul_opcode", 32'(mul_opcode), 32'h0);
        check_output("rst_mul_fmt", 32'(mul_fmt), 32'h0);
        check_output("rst_inflight", 32'(inflight), 32'h0);
        check_output("rst_busy", 32'(busy), 32'h0);
        check_output("rst_ready_idle", 32'(req_ready), 32'h0);

        // Single op from requester 2: 1.5 * 2.0 = 3.0.
        tick();
        set_op(2, 32'h3FC00000, 32'h40000000);
        req_valid = 4'b0100;
        #1;
        check_output("single_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = 4'b0000;
        #1;
        check_output("single_mul_x", mul_x, 32'h3FC00000);
        check_output("single_mul_y", mul_y, 32'h40000000);
        check_output("single_mul_opcode", 32'(mul_opcode), 32'(MUL));
        check_output("single_mul_fmt", 32'(mul_fmt), 32'(FP16ALT));
        check_output("single_inflight_c1", 32'(inflight), 32'h1);
        check_output("single_busy_c1", 32'(busy), 32'h1);
        check_output("single_rsp_c1", 32'(rsp_valid), 32'h0);
        tick();
        check_output("single_inflight_c2", 32'(inflight), 32'h1);
        check_output("single_rsp_c2", 32'(rsp_valid), 32'h0);
        tick();
        check_output("single_rsp_valid", 32'(rsp_valid), 32'h4);
        check_output("single_rsp_data", rsp_data, 32'h40400000);
        check_output("single_inflight_c3", 32'(inflight), 32'h1);
        tick();
        check_output("single_rsp_off", 32'(rsp_valid), 32'h0);
        check_output("single_rsp_hold", rsp_data, 32'h40400000);
        check_output("single_inflight_end", 32'(inflight), 32'h0);
        check_output("single_busy_end", 32'(busy), 32'h0);

        // Fairness: all four valid for 8 cycles from pointer 0.
        do_reset();
        set_op(0, 32'h3F800000, 32'h40000000);
        set_op(1, 32'h40000000, 32'h40000000);
        set_op(2, 32'h40400000, 32'h40000000);
        set_op(3, 32'h40800000, 32'h40000000);
        for (int k = 0; k < 11; k++) begin
            req_valid = (k < 8) ? 4'hF : 4'h0;
            #1;
            if (k < 8)
                check_output($sformatf("fair_ready_%0d", k), 32'(req_ready), 32'(1 << (k % 4)));
            if (k >= 3) begin
                check_output($sformatf("fair_rsp_valid_%0d", k), 32'(rsp_valid), 32'(1 << ((k - 3) % 4)));
                check_output($sformatf("fair_rsp_data_%0d", k), rsp_data, fair_r[(k - 3) % 4]);
            end
            if (k == 5)
                check_output("fair_inflight_steady", 32'(inflight), 32'h3);
            tick();
        end

        // Back-to-back: requester 1 alone for 5 cycles with changing operands.
        for (int k = 0; k < 9; k++) begin
            if (k < 5) begin
                req_valid = 4'b0010;
                set_op(1, bb_x[k], 32'h40000000);
            end else begin
                req_valid = 4'b0000;
            end
            #1;
            if (k < 5)
                check_output($sformatf("b2b_ready_%0d", k), 32'(req_ready), 32'h2);
            if (k >= 3 && k < 8) begin
                check_output($sformatf("b2b_rsp_valid_%0d", k), 32'(rsp_valid), 32'h2);
                check_output($sformatf("b2b_rsp_data_%0d", k), rsp_data, bb_r[k - 3]);
            end
            acc = (k < 5) ? k : 5;
            rs  = (k < 3) ? 0 : ((k - 3 > 5) ? 5 : k - 3);
            check_output($sformatf("b2b_inflight_%0d", k), 32'(inflight), 32'(acc - rs));
            tick();
        end

        // hold: requesters 0 and 3 wait; pointer sits at 2, so 3 wins first on release.
        req_valid = 4'b1001;
        hold      = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check_output($sformatf("hold_ready_%0d", k), 32'(req_ready), 32'h0);
            tick();
        end
        hold = 1'b0;
        #1;
        check_output("hold_release_first", 32'(req_ready), 32'h8);
        tick();
        check_output("hold_release_second", 32'(req_ready), 32'h1);
        tick();
        hold = 1'b1;
        #1;
        check_output("hold_reassert_ready", 32'(req_ready), 32'h0);
        tick();
        check_output("hold_drain_rsp3", 32'(rsp_valid), 32'h8);
        check_output("hold_drain_data3", rsp_data, 32'h41000000);
        tick();
        check_output("hold_drain_rsp0", 32'(rsp_valid), 32'h1);
        check_output("hold_drain_data0", rsp_data, 32'h40000000);
        req_valid = 4'b0000;
        hold      = 1'b0;
        tick();

        // Mask: requester 0 valid but disabled, then enabled in the same cycle.
        req_en    = 4'b1110;
        req_valid = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            #1;
            check_output($sformatf("mask_ready_%0d", k), 32'(req_ready), 32'h0);
            tick();
        end
        req_en = 4'b1111;
        #1;
        check_output("mask_enable_same_cycle", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'b0000;
        tick();
        tick();
        check_output("mask_rsp_valid", 32'(rsp_valid), 32'h1);
        check_output("mask_rsp_data", rsp_data, 32'h40000000);
        tick();

        // Reset mid-flight: three accepts, rst, then restart scanning from index 0.
        set_op(1, 32'h3FC00000, 32'h40000000);
        set_op(2, 32'h40000000, 32'h40000000);
        req_valid = 4'b0110;
        #1;
        check_output("mid_ready_0", 32'(req_ready), 32'h2);
        tick();
        check_output("mid_ready_1", 32'(req_ready), 32'h4);
        tick();
        check_output("mid_ready_2", 32'(req_ready), 32'h2);
        tick();
        rst = 1'b1;
        #1;
        check_output("mid_ready_in_rst", 32'(req_ready), 32'h0);
        check_output("mid_rsp_in_rst", 32'(rsp_valid), 32'h0);
        tick();
        rst = 1'b0;
        #1;
        check_output("mid_ready_after_rst", 32'(req_ready), 32'h2);
        check_output("mid_inflight_after_rst", 32'(inflight), 32'h0);
        check_output("mid_busy_after_rst", 32'(busy), 32'h0);
        check_output("mid_rsp_after_rst", 32'(rsp_valid), 32'h0);
        tick();
        req_valid = 4'b0000;
        #1;
        check_output("mid_rsp_discard_a", 32'(rsp_valid), 32'h0);
        check_output("mid_inflight_new", 32'(inflight), 32'h1);
        tick();
        check_output("mid_rsp_discard_b", 32'(rsp_valid), 32'h0);
        tick();
        check_output("mid_rsp_new_valid", 32'(rsp_valid), 32'h2);
        check_output("mid_rsp_new_data", rsp_data, 32'h40400000);
        tick();
        check_output("mid_rsp_end", 32'(rsp_valid), 32'h0);
        check_output("mid_inflight_end", 32'(inflight), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bf16_mult_arbiter.md
Name: bf16_mult_arbiter

Overview:
- Shares one pipelined bf16 multiplier (fixed latency MULT_LAT) among NUM_REQ requesters.
- Uses round-robin arbitration with a per-requester valid/ready handshake on the request side.
- Registers the granted operands into the multiplier and tags each operation in flight.
- Returns each result to its originating requester as a one-hot response strobe. Sits between the vector/scalar issue logic and the multiplier core.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MULT_LAT, 1, cycles from multiplier operand inputs to valid R (equals the multiplier's PARAM_PIPE).
- IDX_W, $clog2(NUM_REQ), width of the requester index.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester grant/accept.
- req_opcode  in  NUM_REQ x fp_op_e  per-requester opcode (unpacked array).
- req_fmt  in  NUM_REQ x fp_fmt_e  per-requester format.
- req_x  in  NUM_REQ*32  operand X, requester i at bits [32i+31:32i].
- req_y  in  NUM_REQ*32  operand Y, same packing as req_x.
- req_en  in  NUM_REQ  static requester enable mask.
- hold  in  1  suspends new grants.
- mul_opcode  out  fp_op_e  opcode to multiplier.
- mul_fmt  out  fp_fmt_e  format to multiplier.
- mul_x  out  32  operand X to multiplier.
- mul_y  out  32  operand Y to multiplier.
- mul_r  in  32  multiplier result.
- rsp_valid  out  NUM_REQ  one-hot result strobe.
- rsp_data  out  32  result data.
- inflight  out  $clog2(MULT_LAT+3)  operations issued but not yet returned.
- busy  out  1  high when inflight != 0.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, mul_x=0, mul_y=0, mul_opcode/mul_fmt = enum value 0, inflight=0, busy=0, round-robin pointer=0, tag pipeline cleared.
- Eligibility: requester i is eligible when req_valid[i] & req_en[i] & ~hold.
- Grant selection (combinational): grant the first eligible index scanning pointer, pointer+1, … modulo NUM_REQ.
  - req_ready is the one-hot grant. It is all-zero when nothing is eligible, and during rst.
- Handshake: an op is accepted in cycle c when req_valid[i] & req_ready[i].
  - Requesters must hold valid and data stable until accepted.
  - At most one accept per cycle.
- Pointer update: on accept from index g, pointer <= (g+1) mod NUM_REQ. With no accept, the pointer is unchanged.
- Issue stage (registered): on accept in cycle c, mul_x/mul_y/mul_opcode/mul_fmt take the granted requester's fields, visible in cycle c+1. Without an accept, these outputs hold their previous values.
- Tag pipeline:
  - Depth MULT_LAT+1.
  - Entry = {valid, IDX_W index}.
  - Stage 0 loads {accept, g} at the accept edge.
  - Shifts every cycle; no stall.
- Result capture: when the last tag stage is valid (cycle c+1+MULT_LAT), mul_r is captured.
  - rsp_data <= mul_r.
  - rsp_valid <= onehot(index), both visible in cycle c+2+MULT_LAT.
  - Otherwise rsp_valid <= 0 and rsp_data holds.
- Latency and throughput: total latency is MULT_LAT+2 cycles (3 at default). Throughput is one op per cycle. Responses cannot be back-pressured; requesters must always accept them.
- In-flight count: inflight +1 on accept, -1 on rsp_valid; both in the same cycle leaves it unchanged. Maximum is MULT_LAT+2; no overflow is possible.
- hold:
  - Blocks only new grants.
  - Already-accepted ops complete and return normally.
  - Deasserting hold resumes arbitration from the unchanged pointer.
- req_en: a masked requester is never granted, even when valid. A mask change takes effect in the same cycle (combinational).
- Reset mid-operation: all in-flight ops are discarded and no rsp_valid appears for them. Arbitration restarts at index 0 on the first cycle after rst deasserts.
- Simultaneous events: an accept and a response in the same cycle are independent. The same requester may be accepted and receive a response in one cycle.

Test Plan:
- Single op: requester 2 sends X=0x3FC00000 (1.5), Y=0x40000000 (2.0) at cycle 5, MULT_LAT=1 -> req_ready[2]=1 in cycle 5; mul_x=0x3FC00000 in cycle 6; rsp_valid=4'b0100 with rsp_data=0x40400000 (3.0) in cycle 8; inflight 1 for cycles 6-8, then 0.
- Fairness: all four requesters hold req_valid for 8 cycles -> grants 0,1,2,3,0,1,2,3; responses return in the same order, 3 cycles after each grant.
- Back-to-back: only requester 1 valid for 5 cycles -> 5 accepts on consecutive cycles; 5 consecutive rsp_valid=4'b0010; inflight peaks at 3.
- hold and mask:
  - hold=1 for cycles 10-14 with requesters 0 and 3 valid -> no req_ready in cycles 10-14; grant resumes at the saved pointer in cycle 15.
  - req_en=4'b1110 with only requester 0 valid -> never granted.
- Reset mid-flight: accepts in cycles 3, 4 and 5, rst in cycle 6 -> no rsp_valid in cycles 6-10; inflight=0 from cycle 7; the first grant after reset scans from index 0.
